// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with an optional skid entry.
// SKID=1 breaks the ready path; SKID=0 is a single pass-through register.
module pipe_stage #(
    parameter int unsigned      WIDTH       = 32,
    parameter int               SKID        = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_xfer;
    logic             out_xfer;

    // Skid mode ready comes straight off a flop; pass mode looks ahead.
    assign in_ready_o  = (SKID != 0) ? !skid_valid_q
                                     : (!main_valid_q || out_ready_i);
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign count_o     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    assign in_xfer  = in_valid_i && in_ready_o && !flush_i;
    assign out_xfer = main_valid_q && out_ready_i && !flush_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid_q) begin
                if (in_xfer) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data_i;
                end
            end else if (out_xfer) begin
                if (skid_valid_q) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    main_data_d = in_data_i;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end else begin
            if (in_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end else if (out_xfer) begin
                main_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_VALUE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_VALUE;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed and scoreboarded bench for pipe_stage, skid and pass modes.
module tb_pipe_stage;

    localparam logic [31:0] RV_S = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy_s, ov_s, rdy_p, ov_p;
    logic [31:0] od_s, od_p;
    logic [1:0]  cnt_s, cnt_p;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage #(.WIDTH(32), .SKID(1), .RESET_VALUE(RV_S)) u_skid (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy_s), .in_data_i(in_data),
        .out_valid_o(ov_s), .out_ready_i(out_ready), .out_data_o(od_s),
        .count_o(cnt_s)
    );

    pipe_stage #(.WIDTH(32), .SKID(0)) u_pass (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy_p), .in_data_i(in_data),
        .out_valid_o(ov_p), .out_ready_i(out_ready), .out_data_o(od_p),
        .count_o(cnt_p)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vt[16];
    logic [31:0] qs[$];
    logic [31:0] qp[$];

    initial begin
        vt[0]  = '{0, 1, 32'hA5A5A5A5, 1, 1, 32'hA5A5A5A5, 1, 1};
        vt[1]  = '{0, 0, 32'h0, 1, 0, 32'hA5A5A5A5, 0, 1};
        vt[2]  = '{0, 1, 32'h1, 0, 1, 32'h1, 1, 1};
        vt[3]  = '{0, 1, 32'h2, 0, 1, 32'h1, 2, 0};
        vt[4]  = '{0, 1, 32'h3, 0, 1, 32'h1, 2, 0};
        vt[5]  = '{0, 1, 32'h3, 1, 1, 32'h2, 1, 1};
        vt[6]  = '{0, 0, 32'h0, 1, 0, 32'h2, 0, 1};
        vt[7]  = '{0, 1, 32'h10, 1, 1, 32'h10, 1, 1};
        vt[8]  = '{0, 1, 32'h11, 1, 1, 32'h11, 1, 1};
        vt[9]  = '{0, 1, 32'h12, 0, 1, 32'h11, 2, 0};
        vt[10] = '{1, 1, 32'h13, 1, 0, 32'h11, 0, 1};
        vt[11] = '{0, 0, 32'h0, 0, 0, 32'h11, 0, 1};
        vt[12] = '{0, 1, 32'h20, 0, 1, 32'h20, 1, 1};
        vt[13] = '{0, 1, 32'h21, 0, 1, 32'h20, 2, 0};
        vt[14] = '{0, 0, 32'h0, 1, 1, 32'h21, 1, 1};
        vt[15] = '{0, 0, 32'h0, 1, 0, 32'h21, 0, 1};

        // reset state
        #12;
        chk("rst_s_ov", ov_s, 0);
        chk("rst_s_od", od_s, RV_S);
        chk("rst_s_cnt", cnt_s, 0);
        chk("rst_s_rdy", rdy_s, 1);
        chk("rst_p_ov", ov_p, 0);
        chk("rst_p_od", od_p, 0);
        chk("rst_p_cnt", cnt_p, 0);
        chk("rst_p_rdy", rdy_p, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vt[i]) begin
            flush = vt[i].fl;
            in_valid = vt[i].iv;
            in_data = vt[i].din;
            out_ready = vt[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_ov", i), ov_s, vt[i].e_ov);
            chk($sformatf("v%0d_od", i), od_s, vt[i].e_od);
            chk($sformatf("v%0d_cnt", i), cnt_s, vt[i].e_cnt);
            chk($sformatf("v%0d_rdy", i), rdy_s, vt[i].e_rdy);
        end
        flush = 1'b0;

        // fill skid stage, then async reset between edges
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h55;
        @(posedge clk); #1;
        in_data = 32'h66;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fill_cnt", cnt_s, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s_ov", ov_s, 0);
        chk("arst_s_cnt", cnt_s, 0);
        chk("arst_s_od", od_s, RV_S);
        chk("arst_s_rdy", rdy_s, 1);
        chk("arst_p_ov", ov_p, 0);
        chk("arst_p_cnt", cnt_p, 0);
        chk("arst_p_rdy", rdy_p, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back stream, both modes
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = i;
            @(posedge clk); #1;
            chk($sformatf("str_s%0d", i), {ov_s, od_s[30:0]},
                {1'b1, 31'(i)});
            chk($sformatf("str_p%0d", i), {ov_p, od_p[30:0]},
                {1'b1, 31'(i)});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        // random handshakes against queue models
        for (int c = 0; c < 10000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = $urandom;
            #2;
            chk("rnd_s_cnt", cnt_s, qs.size());
            chk("rnd_s_rdy", rdy_s, qs.size() < 2);
            chk("rnd_s_ov", ov_s, qs.size() != 0);
            if (ov_s && qs.size() != 0) chk("rnd_s_od", od_s, qs[0]);
            chk("rnd_p_cnt", cnt_p, qp.size());
            chk("rnd_p_rdy", rdy_p, qp.size() == 0 || out_ready);
            chk("rnd_p_ov", ov_p, qp.size() != 0);
            if (ov_p && qp.size() != 0) chk("rnd_p_od", od_p, qp[0]);
            if (ov_s && out_ready && qs.size() != 0) void'(qs.pop_front());
            if (in_valid && rdy_s) qs.push_back(in_data);
            if (ov_p && out_ready && qp.size() != 0) void'(qp.pop_front());
            if (in_valid && rdy_p) qp.push_back(in_data);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
